prog_load_sequencer: RTL and testbench

//  Sequences the UART program-load path into program memory, ahead of the CPU.

---
 rtl/prog_load_sequencer.sv | 101 ++++++++++
 tb/tb_prog_load_sequencer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_load_sequencer.sv
// UART program loader: packs received bytes into little-endian words, writes them to
// program memory, and releases the CPU once the sentinel word arrives.
module prog_load_sequencer #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = 256,
  parameter logic [31:0] SENTINEL  = 32'hFFFF_FFFF,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              reload_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [31:0]       mem_wdata,
  output logic              run_flag,
  output logic              cpu_stall,
  output logic [ADDR_W-2:0] word_count,
  output logic              overflow_err,
  output logic              timeout_err
);

  localparam int unsigned IdleW = $clog2(TIMEOUT + 1);
  localparam logic [IdleW-1:0]  TimeoutLast = IdleW'(TIMEOUT - 1);
  localparam logic [ADDR_W-2:0] MaxWords    = (ADDR_W - 1)'(MAX_WORDS);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StError} state_e;

  state_e           state;
  logic [1:0]       byte_cnt;
  logic [23:0]      asm_word;  // bytes 0..2; byte 3 comes straight from rx_data
  logic [IdleW-1:0] idle_cnt;
  logic [31:0]      full_word;

  assign full_word = {rx_data, asm_word};
  assign cpu_stall = ~run_flag;

  // word_count doubles as the write word index: both advance together on every write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= StIdle;
      byte_cnt     <= '0;
      asm_word     <= '0;
      idle_cnt     <= '0;
      mem_we       <= 1'b0;
      mem_waddr    <= '0;
      mem_wdata    <= '0;
      run_flag     <= 1'b0;
      word_count   <= '0;
      overflow_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (reload_req) begin
        state        <= StIdle;
        byte_cnt     <= '0;
        idle_cnt     <= '0;
        run_flag     <= 1'b0;
        word_count   <= '0;
        overflow_err <= 1'b0;
        timeout_err  <= 1'b0;
      end else if (state == StIdle || state == StLoad) begin
        if (rx_valid) begin
          idle_cnt <= '0;
          byte_cnt <= byte_cnt + 2'd1;
          state    <= StLoad;
          case (byte_cnt)
            2'd0: asm_word[7:0]   <= rx_data;
            2'd1: asm_word[15:8]  <= rx_data;
            2'd2: asm_word[23:16] <= rx_data;
            default: begin
              if (full_word == SENTINEL) begin
                state    <= StRun;
                run_flag <= 1'b1;
              end else if (word_count == MaxWords) begin
                state        <= StError;
                overflow_err <= 1'b1;
              end else begin
                mem_we     <= 1'b1;
                mem_waddr  <= {word_count[ADDR_W-3:0], 2'b00};
                mem_wdata  <= full_word;
                word_count <= word_count + (ADDR_W - 1)'(1);
              end
            end
          endcase
        end else if (state == StLoad && byte_cnt != 2'd0) begin
          // A stalled partial word is abandoned; the next byte starts a fresh word.
          if (idle_cnt == TimeoutLast) begin
            byte_cnt    <= '0;
            idle_cnt    <= '0;
            timeout_err <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + IdleW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_prog_load_sequencer.sv
// Bench for prog_load_sequencer: directed scenarios plus random byte streams, checked by a
// byte-level reference model and a write scoreboard.
module tb_prog_load_sequencer;
  localparam int unsigned ADDR_W    = 6;
  localparam int unsigned MAX_WORDS = 4;
  localparam logic [31:0] SENTINEL  = 32'hFFFF_FFFF;
  localparam int unsigned TIMEOUT   = 12;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic              clk;
  logic              reset_n;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              reload_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [31:0]       mem_wdata;
  logic              run_flag;
  logic              cpu_stall;
  logic [ADDR_W-2:0] word_count;
  logic              overflow_err;
  logic              timeout_err;

  prog_load_sequencer #(
    .ADDR_W   (ADDR_W),
    .MAX_WORDS(MAX_WORDS),
    .SENTINEL (SENTINEL),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .reload_req  (reload_req),
    .mem_we      (mem_we),
    .mem_waddr   (mem_waddr),
    .mem_wdata   (mem_wdata),
    .run_flag    (run_flag),
    .cpu_stall   (cpu_stall),
    .word_count  (word_count),
    .overflow_err(overflow_err),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: 0 = loading, 1 = running, 2 = overflowed.
  int         m_mode = 0;
  logic [7:0] m_part[$];
  int         m_count = 0;
  bit         m_oerr = 0;
  bit         m_terr = 0;
  int         m_since = 0;
  wr_t        exp_q[$];

  int cycle = 0;
  int last_we = -1;
  int prev_we = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write monitor / scoreboard.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      cycle++;
      if (mem_we === 1'b1) begin
        prev_we = last_we;
        last_we = cycle;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                   mem_waddr, mem_wdata);
        end else begin
          w = exp_q.pop_front();
          chk("write_addr", 32'(mem_waddr), 32'(w.addr));
          chk("write_data", mem_wdata, w.data);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic model_timeout();
    if (m_mode == 0 && m_part.size() != 0 && m_since >= TIMEOUT) begin
      m_part.delete();
      m_terr = 1;
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_part.delete();
    m_count = 0;
    m_oerr = 0;
    m_terr = 0;
    m_since = 0;
  endtask

  task automatic check_status(input string tag);
    model_timeout();
    chk({tag, ".run_flag"}, 32'(run_flag), 32'(m_mode == 1));
    chk({tag, ".cpu_stall"}, 32'(cpu_stall), 32'(m_mode != 1));
    chk({tag, ".word_count"}, 32'(word_count), 32'(m_count));
    chk({tag, ".overflow_err"}, 32'(overflow_err), 32'(m_oerr));
    chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(m_terr));
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    wr_t w;
    logic [31:0] word;
    repeat (gap) begin
      cyc();
      m_since++;
    end
    model_timeout();
    if (m_mode == 0) begin
      m_part.push_back(b);
      if (m_part.size() == 4) begin
        word = 32'(m_part[0]) + (32'(m_part[1]) << 8) + (32'(m_part[2]) << 16)
             + (32'(m_part[3]) << 24);
        m_part.delete();
        if (word == SENTINEL) begin
          m_mode = 1;
        end else if (m_count == MAX_WORDS) begin
          m_mode = 2;
          m_oerr = 1;
        end else begin
          w.addr = ADDR_W'(m_count * 4);
          w.data = word;
          exp_q.push_back(w);
          m_count++;
        end
      end
    end
    m_since = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    cyc();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] word, input int gap);
    logic [31:0] v;
    v = word;
    for (int i = 0; i < 4; i++) send(v[8*i+:8], gap);
  endtask

  task automatic reload(input bit with_byte);
    reload_req = 1'b1;
    rx_valid   = with_byte;
    rx_data    = 8'h5A;
    cyc();
    reload_req = 1'b0;
    rx_valid   = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, ".mem_waddr"}, 32'(mem_waddr), 32'd0);
    chk({tag, ".mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, ".run_flag"}, 32'(run_flag), 32'd0);
    chk({tag, ".cpu_stall"}, 32'(cpu_stall), 32'd1);
    chk({tag, ".word_count"}, 32'(word_count), 32'd0);
    chk({tag, ".overflow_err"}, 32'(overflow_err), 32'd0);
    chk({tag, ".timeout_err"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    logic [7:0] prog[12];
    prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
             8'hFF, 8'hFF, 8'hFF, 8'hFF};
    reset_n    = 1'b0;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    reload_req = 1'b0;
    #2;
    check_reset_outputs("reset");
    cyc();
    cyc();
    reset_n = 1'b1;

    // Spaced program load ending in the sentinel.
    for (int i = 0; i < 12; i++) send(prog[i], 2);
    check_status("spaced_load");
    chk("spaced_load.count2", 32'(word_count), 32'd2);
    reload(1'b0);
    check_status("reload_run");

    // Back-to-back bytes: writes four cycles apart, then reload with a colliding byte.
    for (int i = 0; i < 12; i++) send(prog[i], 0);
    check_status("b2b_load");
    chk("b2b_we_spacing", 32'(last_we - prev_we), 32'd4);
    reload(1'b1);
    check_status("reload_with_byte");
    send_word(32'hCAFE_0001, 0);
    check_status("after_reload_word");
    reload(1'b0);

    // Overflow: one more data word than fits, then trailing bytes are ignored.
    for (int i = 0; i <= MAX_WORDS; i++) send_word(32'h1000_0000 + i, 1);
    check_status("overflow");
    send_word(SENTINEL, 0);
    check_status("overflow_ignores");
    reload(1'b0);

    // Timeout boundary: TIMEOUT-1 idle cycles keep the partial word, TIMEOUT discards it.
    send(8'hCC, 0);
    send(8'hDD, 0);
    send(8'hEE, TIMEOUT - 1);
    send(8'h01, 0);
    check_status("no_timeout");
    send(8'hAA, 0);
    send(8'hBB, 0);
    repeat (TIMEOUT) begin
      cyc();
      m_since++;
    end
    check_status("timeout_fired");
    send_word(32'h4433_2211, 0);
    check_status("after_timeout");
    reload(1'b0);

    // Asynchronous reset in the middle of a word.
    send_word(32'h0BAD_F00D, 0);
    cyc();
    cyc();
    send(8'h77, 0);
    send(8'h66, 0);
    #2 reset_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    cyc();
    cyc();
    reset_n = 1'b1;
    send_word(32'h8765_4321, 1);
    check_status("after_async_reset");

    // Random byte streams with occasional reloads.
    for (int n = 0; n < 400; n++) begin
      int gsel;
      int gap;
      logic [7:0] b;
      if ((m_mode != 0 && $urandom_range(0, 3) == 0) || $urandom_range(0, 39) == 0) begin
        reload(1'($urandom_range(0, 1)));
      end else begin
        gsel = $urandom_range(0, 19);
        if (gsel < 14) gap = 0;
        else if (gsel < 17) gap = $urandom_range(1, 3);
        else if (gsel == 17) gap = TIMEOUT - 1;
        else if (gsel == 18) gap = TIMEOUT;
        else gap = TIMEOUT + 2;
        b = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
        send(b, gap);
      end
      check_status("random");
    end

    cyc();
    cyc();
    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
